enc_debounce: RTL and testbench

- Per-channel synchronizer and debouncer for the raw Pmod rotary encoder pins (A, B, BTN, SW).
- Sits directly upstream of the encoder core's edge detectors. Each debounced level feeds one edge detector's level input.
- Guarantees that every level it presents has been stable for DB_CYCLES consecutive clocks, so the downstream ticks see exactly one edge per physical transition.

---
 rtl/pmod_enc_pkg.sv | 18 +
 rtl/db_channel.sv | 96 +++++++++
 rtl/enc_debounce.sv | 35 +++
 tb/tb_enc_debounce.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_enc_pkg.sv
// Shared types and channel indices for the Pmod rotary encoder front end.
package pmod_enc_pkg;

  // bit1 = debounced level, bit0 = qualifying a candidate change
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  localparam int unsigned ENC_A      = 0;
  localparam int unsigned ENC_B      = 1;
  localparam int unsigned ENC_BTN    = 2;
  localparam int unsigned ENC_SW     = 3;
  localparam int unsigned ENC_NUM_CH = 4;

endpackage

// File: rtl/db_channel.sv
// One debounce channel: optional two-flop synchronizer, level FSM and run counter.
// ENC_DB_SYNC_EN selects the synchronizer; otherwise raw is sampled directly.
module db_channel
  import pmod_enc_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  localparam db_state_t RST_STATE = RESET_VAL ? ONE : ZERO;

  logic            in_s;
  db_state_t       state;
  logic [CNT_W-1:0] cnt;

`ifdef ENC_DB_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign in_s = s2;
`else
  assign in_s = raw;
`endif

  // A candidate value must be seen DB_CYCLES times in a row; any reversion restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      case (state)
        ZERO: begin
          if (in_s) begin
            state <= WAIT1;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT1: begin
          if (!in_s) begin
            state <= ZERO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ONE: begin
          if (!in_s) begin
            state <= WAIT0;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT0: begin
          if (in_s) begin
            state <= ONE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ZERO;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RST_STATE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are state register bits directly, so no path from raw.
  assign level = state[1];
  assign busy  = state[0];

endmodule

// File: rtl/enc_debounce.sv
// Debouncer bank for the encoder pins (A, B, BTN, SW); one independent channel per bit.
// ENC_DB_SYNC_EN adds a two-flop synchronizer in front of each channel.
module enc_debounce
  import pmod_enc_pkg::*;
#(
  parameter int unsigned    CH        = ENC_NUM_CH,
  parameter int unsigned    DB_CYCLES = 1_000_000,
  parameter logic [CH-1:0]  RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] raw_in,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] db_busy
);

  // A single-sample window would let bounce through; refuse to elaborate.
  if (DB_CYCLES < 2) begin : g_bad_cfg
    $fatal(1, "enc_debounce: DB_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    db_channel #(
      .DB_CYCLES(DB_CYCLES),
      .RESET_VAL(RESET_VAL[i])
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_in[i]),
      .level(db_level[i]),
      .busy (db_busy[i])
    );
  end

endmodule

// File: tb/tb_enc_debounce.sv
// Bench for enc_debounce: run-length reference model checked every cycle plus literal latency/glitch checks.
module tb_enc_debounce;
  import pmod_enc_pkg::*;

  localparam int unsigned CH = ENC_NUM_CH;
  localparam int unsigned DB = 8;
`ifdef ENC_DB_SYNC_EN
  localparam int unsigned SD = 2;
`else
  localparam int unsigned SD = 0;
`endif
  // edges from first capture of a step to the output flip
  localparam int LAT = int'(SD + DB - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw_in = '1;
  logic [CH-1:0] db_level;
  logic [CH-1:0] db_busy;

  int errors = 0;
  int checks = 0;

  enc_debounce #(
    .CH(CH),
    .DB_CYCLES(DB),
    .RESET_VAL('0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_in),
    .db_level(db_level),
    .db_busy (db_busy)
  );

  always #5 clk = ~clk;

  // Reference: the level follows the sampled input once it has disagreed for DB samples in a row.
  logic [CH-1:0] pipe[$];
  logic [CH-1:0] m_level = '0;
  int            m_run[CH];
  logic          check_en = 1'b0;

  initial for (int i = 0; i < int'(SD); i++) pipe.push_back('0);

  always @(posedge clk) begin
    logic [CH-1:0] in_s;
    logic [CH-1:0] exp_busy;
    if (SD == 0) begin
      in_s = raw_in;
    end else begin
      in_s = pipe.pop_front();
      pipe.push_back(raw_in);
    end
    if (reset) begin
      check_en = 1'b1;
      m_level  = '0;
      for (int c = 0; c < int'(CH); c++) m_run[c] = 0;
      pipe.delete();
      for (int i = 0; i < int'(SD); i++) pipe.push_back('0);
    end else begin
      for (int c = 0; c < int'(CH); c++) begin
        if (in_s[c] != m_level[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == int'(DB)) begin
            m_level[c] = in_s[c];
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    for (int c = 0; c < int'(CH); c++) exp_busy[c] = (m_run[c] != 0);
    #1;
    if (check_en) begin
      checks++;
      if (db_level !== m_level) begin
        errors++;
        $display("FAIL model_level t=%0t got=%b want=%b", $time, db_level, m_level);
      end
      checks++;
      if (db_busy !== exp_busy) begin
        errors++;
        $display("FAIL model_busy t=%0t got=%b want=%b", $time, db_busy, exp_busy);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Called after raw is driven at a negedge; counts edges after the capture edge until the flip.
  task automatic measure(input int ch, input logic want, output int n);
    @(posedge clk);
    n = 0;
    while (db_level[ch] !== want && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
  endtask

  task automatic pulse(input int ch, input int len, output int bc, output int rose);
    @(negedge clk);
    raw_in[ch] = 1'b1;
    bc = 0;
    rose = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #2;
      bc += int'(db_busy[ch]);
      if (db_level[ch]) rose = 1;
      @(negedge clk);
      if (k == len - 1) raw_in[ch] = 1'b0;
    end
  endtask

  task automatic toggle_then_hold(input int ch, input logic final_val, output int changes, output int n);
    logic prev;
    prev = db_level[ch];
    changes = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      raw_in[ch] = (((k / 3) % 2) == 0) ? final_val : ~final_val;
      @(posedge clk);
      #2;
      if (db_level[ch] !== prev) changes++;
      prev = db_level[ch];
    end
    @(negedge clk);
    raw_in[ch] = final_val;
    measure(ch, final_val, n);
  endtask

  int n;
  int bc;
  int rose;
  int chg;
  int hold[CH];

  initial begin
    // reset held with all pins high
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      check("rst_level", int'(db_level), 0);
      check("rst_busy", int'(db_busy), 0);
    end
    @(negedge clk);
    reset  = 1'b0;
    raw_in = '0;
    repeat (DB + 4) @(negedge clk);

    // clean rising step on A
    raw_in[ENC_A] = 1'b1;
    measure(ENC_A, 1'b1, n);
    check("step_rise_latency", n, LAT);
    check("step_others_low", int'(db_level[3:1]), 0);
    repeat (4) @(negedge clk);

    // glitches shorter than the window are rejected; exactly DB samples are accepted
    pulse(ENC_B, 5, bc, rose);
    check("glitch5_busy_cycles", bc, 5);
    check("glitch5_no_rise", rose, 0);
    pulse(ENC_B, int'(DB) - 1, bc, rose);
    check("glitch7_busy_cycles", bc, int'(DB) - 1);
    check("glitch7_no_rise", rose, 0);
    pulse(ENC_B, int'(DB), bc, rose);
    check("pulse8_accepted", rose, 1);

    // bouncing input yields a single clean edge each way
    toggle_then_hold(ENC_BTN, 1'b1, chg, n);
    check("bounce_rise_no_early_edge", chg, 0);
    check("bounce_rise_latency", n, LAT);
    toggle_then_hold(ENC_BTN, 1'b0, chg, n);
    check("bounce_fall_no_early_edge", chg, 0);
    check("bounce_fall_latency", n, LAT);

    // reset mid-qualification (cnt=5) discards progress
    @(negedge clk);
    raw_in[ENC_A] = 1'b0;
    repeat (DB + 6) @(negedge clk);
    raw_in[ENC_A] = 1'b1;
    repeat (SD + 5) @(negedge clk);
    check("pre_reset_busy", int'(db_busy[ENC_A]), 1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("midq_reset_level", int'(db_level[ENC_A]), 0);
    check("midq_reset_busy", int'(db_busy), 0);
    @(negedge clk);
    reset = 1'b0;
    measure(ENC_A, 1'b1, n);
    check("post_reset_latency", n, LAT);

    // SW channel step
    @(negedge clk);
    raw_in[ENC_SW] = 1'b1;
    measure(ENC_SW, 1'b1, n);
    check("sw_rise_latency", n, LAT);

    // random bouncing on all channels with occasional resets
    for (int c = 0; c < int'(CH); c++) hold[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < int'(CH); c++) begin
        if (hold[c] == 0) begin
          raw_in[c] = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 14));
        end else begin
          hold[c]--;
        end
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
